text_buffer: RTL and testbench



---
 rtl/text_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_text_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer.sv
// -----------------------------------------------------------------------------
// text_buffer
//   Character-cell frame store feeding the 8x16 glyph renderer. The write side
//   takes a byte stream over a valid/ready handshake, tracks a cursor,
//   interprets control codes and stores printable codes in a COLS x ROWS
//   simple dual-port RAM. The read side returns the code at the renderer's
//   current cell one cycle after the cell address is presented.
//
//   Write codes: 0x00-0x7F printable (stored at cursor, cursor advances),
//                0x80 newline, 0x81 clear screen, 0x82 backspace,
//                0x83-0xFF accepted and ignored.
//
// Ports
//   PixelClk  in   1  single clock for both sides
//   RST       in   1  asynchronous, active-high reset
//   WrValid   in   1  WrData valid this cycle
//   WrData    in   8  code to write / control code
//   WrReady   out  1  byte accepted on an edge where WrValid && WrReady
//   RdCol     in   6  renderer cell column
//   RdRow     in   5  renderer cell row
//   Character out  8  stored code at (RdRow, RdCol), one cycle later
//   CurCol    out  6  cursor column
//   CurRow    out  5  cursor row
//   Busy      out  1  a clear sweep (whole screen or one row) is running
// -----------------------------------------------------------------------------
module text_buffer #(
  parameter int          COLS  = 60,
  parameter int          ROWS  = 17,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       PixelClk,
  input  logic       RST,
  input  logic       WrValid,
  input  logic [7:0] WrData,
  output logic       WrReady,
  input  logic [5:0] RdCol,
  input  logic [4:0] RdRow,
  output logic [7:0] Character,
  output logic [5:0] CurCol,
  output logic [4:0] CurRow,
  output logic       Busy
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int AW     = 11;               // linear cell address width
  localparam int RAM_AW = $clog2(DEPTH);    // bits actually needed to index the RAM

  localparam logic [AW-1:0] COLS_W       = AW'(COLS);
  localparam logic [AW-1:0] LAST_ADDR    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ROW_LAST_OFS = AW'(COLS - 1);
  localparam logic [5:0]    COLS_6       = 6'(COLS);
  localparam logic [4:0]    ROWS_5       = 5'(ROWS);
  localparam logic [5:0]    LAST_COL     = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW     = 5'(ROWS - 1);

  localparam logic [7:0] CODE_NL  = 8'h80;
  localparam logic [7:0] CODE_CLS = 8'h81;
  localparam logic [7:0] CODE_BS  = 8'h82;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_addr;   // whole-screen address in CLR_ALL, column offset in CLR_ROW

  logic [7:0]      mem [0:DEPTH-1];

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return AW'(row) * COLS_W + AW'(col);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and status, decoded straight from the state register
  // ---------------------------------------------------------------------------
  assign WrReady = (state == IDLE);
  assign Busy    = (state != IDLE);

  logic accept;
  logic is_print;
  logic do_newline;

  assign accept     = WrValid && WrReady;
  assign is_print   = ~WrData[7];
  // A printable byte in the last column wraps exactly like an explicit newline.
  assign do_newline = accept && ((is_print && (CurCol == LAST_COL)) || (WrData == CODE_NL));

  // ---------------------------------------------------------------------------
  // RAM write port: sweeps own the port while busy, otherwise the byte stream.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] cur_addr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  assign cur_addr = cell_addr(CurRow, CurCol);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    we    = 1'b0;
    waddr = cur_addr;
    wdata = BLANK;
    case (state)
      CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_addr;
      end
      CLR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr(CurRow, 6'd0) + clr_addr;
      end
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            we    = 1'b1;
            wdata = WrData;
          end else if ((WrData == CODE_BS) && (CurCol != 6'd0)) begin
            // Backspace blanks the cell it moves onto, in the same cycle.
            we    = 1'b1;
            waddr = cur_addr - AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; the power-up
  // CLR_ALL sweep is what gives it defined contents.
  always_ff @(posedge PixelClk) begin
    if (we) mem[RAM_AW'(waddr)] <= wdata;
  end

  // ---------------------------------------------------------------------------
  // RAM read port: registered, independent of write state. A same-cell write
  // in the same cycle is not forwarded, so the old contents are returned.
  // ---------------------------------------------------------------------------
  logic          rd_in_range;
  logic [AW-1:0] raddr;

  assign rd_in_range = (RdCol < COLS_6) && (RdRow < ROWS_5);
  assign raddr       = cell_addr(RdRow, RdCol);

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      Character <= BLANK;
    end else if (rd_in_range) begin
      Character <= mem[RAM_AW'(raddr)];
    end else begin
      Character <= BLANK;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and cursor
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      state    <= CLR_ALL;
      clr_addr <= '0;
      CurCol   <= '0;
      CurRow   <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            clr_addr <= '0;
            CurCol   <= '0;
            CurRow   <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end

        CLR_ROW: begin
          if (clr_addr == ROW_LAST_OFS) begin
            state    <= IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end

        IDLE: begin
          if (do_newline) begin
            CurCol <= '0;
            if (CurRow == LAST_ROW) begin
              // Wrap to the top without scrolling; the row being reused is blanked.
              CurRow   <= '0;
              state    <= CLR_ROW;
              clr_addr <= '0;
            end else begin
              CurRow <= CurRow + 5'd1;
            end
          end else if (accept) begin
            if (is_print) begin
              CurCol <= CurCol + 6'd1;
            end else if (WrData == CODE_CLS) begin
              state    <= CLR_ALL;
              clr_addr <= '0;
            end else if ((WrData == CODE_BS) && (CurCol != 6'd0)) begin
              CurCol <= CurCol - 6'd1;
            end
          end
        end

        default: begin
          state    <= CLR_ALL;
          clr_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// -----------------------------------------------------------------------------
// tb_text_buffer
//   Directed bench for text_buffer. Each read request pushes its hand-computed
//   expected code into a queue; a monitor pops and compares when Character
//   becomes valid one cycle later. Cursor and status are checked directly.
// -----------------------------------------------------------------------------
module tb_text_buffer;

  localparam int COLS  = 60;
  localparam int ROWS  = 17;
  localparam int DEPTH = COLS * ROWS;

  logic       PixelClk = 1'b0;
  logic       RST      = 1'b1;
  logic       WrValid  = 1'b0;
  logic [7:0] WrData   = 8'h00;
  logic [5:0] RdCol    = 6'd0;
  logic [4:0] RdRow    = 5'd0;
  logic       WrReady;
  logic [7:0] Character;
  logic [5:0] CurCol;
  logic [4:0] CurRow;
  logic       Busy;

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .PixelClk  (PixelClk),
    .RST       (RST),
    .WrValid   (WrValid),
    .WrData    (WrData),
    .WrReady   (WrReady),
    .RdCol     (RdCol),
    .RdRow     (RdRow),
    .Character (Character),
    .CurCol    (CurCol),
    .CurRow    (CurRow),
    .Busy      (Busy)
  );

  always #5 PixelClk = ~PixelClk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Read scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic [4:0] row;
    logic [5:0] col;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  logic    rd_req = 1'b0;
  logic    rd_vld = 1'b0;
  bit      count_en = 1'b0;
  int      count9 = 0;

  always @(posedge PixelClk) rd_vld <= rd_req;

  always @(negedge PixelClk) begin : monitor
    rd_exp_t e;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_q_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        if (count_en && (Character == 8'h09)) count9++;
        check($sformatf("rd(%0d,%0d)", e.row, e.col), Character, e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called and returning at a negedge)
  // ---------------------------------------------------------------------------
  task automatic read_cell(input int row, input int col, input logic [7:0] exp);
    RdRow  = 5'(row);
    RdCol  = 6'(col);
    rd_req = 1'b1;
    exp_q.push_back('{data: exp, row: 5'(row), col: 6'(col)});
    @(negedge PixelClk);
    rd_req = 1'b0;
  endtask

  task automatic read_row(input int row, input logic [7:0] exp);
    for (int c = 0; c < COLS; c++) read_cell(row, c, exp);
  endtask

  task automatic drain();
    repeat (3) @(negedge PixelClk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    WrData  = b;
    WrValid = 1'b1;
    while (!WrReady && n < 3000) begin
      @(negedge PixelClk);
      n++;
    end
    check($sformatf("send_ready_%02h", b), WrReady, 1);
    @(negedge PixelClk);
    WrValid = 1'b0;
  endtask

  // Counts negedges with Busy=1 starting at the current one; WrReady must be
  // low for all of them.
  task automatic measure_busy(input string name, input int exp);
    int n   = 0;
    int bad = 0;
    while (Busy && n < 5000) begin
      if (WrReady) bad++;
      n++;
      @(negedge PixelClk);
    end
    check(name, n, exp);
    check({name, "_wrready_low"}, bad, 0);
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, "_row"}, CurRow, row);
    check({name, "_col"}, CurCol, col);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    int hs;

    // Reset values
    RST = 1'b1;
    repeat (3) @(negedge PixelClk);
    check("rst_character", Character, 8'h20);
    check("rst_wrready", WrReady, 0);
    check("rst_busy", Busy, 1);
    check_cursor("rst_cursor", 0, 0);

    // Power-up sweep: exactly 1020 busy cycles, then everything blank
    RST = 1'b0;
    measure_busy("init_busy_cycles", DEPTH);
    check("init_idle_busy", Busy, 0);
    check("init_idle_wrready", WrReady, 1);
    check_cursor("init_cursor", 0, 0);
    for (int r = 0; r < ROWS; r++) read_row(r, 8'h20);
    read_cell(17, 0, 8'h20);
    read_cell(0, 60, 8'h20);
    read_cell(31, 63, 8'h20);

    // Write 0x03 while reading the same cell: old contents come back
    WrData  = 8'h03;
    WrValid = 1'b1;
    check("rdy_before_same_cell", WrReady, 1);
    read_cell(0, 0, 8'h20);
    WrValid = 1'b0;
    send(8'h07);
    check_cursor("two_bytes_cursor", 0, 2);
    read_cell(0, 0, 8'h03);
    read_cell(0, 1, 8'h07);
    read_cell(0, 2, 8'h20);

    // Clear screen: 1020 busy cycles, cursor home, cells blank
    send(8'h81);
    measure_busy("cls_busy_cycles", DEPTH);
    check_cursor("cls_cursor", 0, 0);
    read_cell(0, 0, 8'h20);
    read_cell(0, 1, 8'h20);

    // Fill row 0 -> wrap to row 1 col 0; backspace at col 0 does nothing
    repeat (COLS) send(8'h05);
    check_cursor("fill_row_cursor", 1, 0);
    check("fill_row_busy", Busy, 0);
    read_row(0, 8'h05);
    read_cell(1, 0, 8'h20);
    send(8'h82);
    check_cursor("bs_at_col0_cursor", 1, 0);

    // Printable then backspace blanks the cell
    send(8'h01);
    check_cursor("after_01_cursor", 1, 1);
    read_cell(1, 0, 8'h01);
    send(8'h82);
    check_cursor("after_bs_cursor", 1, 0);
    read_cell(1, 0, 8'h20);

    // Mark row 1, then 16 newlines wrap to row 0 and clear only row 0
    send(8'h0A);
    for (int i = 0; i < 15; i++) send(8'h80);
    check_cursor("nl15_cursor", 16, 0);
    check("nl15_busy", Busy, 0);
    send(8'h80);
    check_cursor("nl_wrap_cursor", 0, 0);
    measure_busy("row_clr_busy_cycles", COLS);
    read_row(0, 8'h20);
    read_cell(1, 0, 8'h0A);

    // Mid-screen clear, interrupted by reset at sweep cycle 500
    send(8'h41);
    send(8'h42);
    send(8'h80);
    send(8'h43);
    check_cursor("pre_cls_cursor", 1, 1);
    send(8'h81);
    repeat (500) @(negedge PixelClk);
    check("mid_sweep_busy", Busy, 1);
    check_cursor("mid_sweep_cursor_held", 1, 1);
    RST = 1'b1;
    #1;
    check("mid_rst_busy", Busy, 1);
    check("mid_rst_wrready", WrReady, 0);
    check("mid_rst_character", Character, 8'h20);
    check_cursor("mid_rst_cursor", 0, 0);
    @(negedge PixelClk);
    RST = 1'b0;
    measure_busy("restart_busy_cycles", DEPTH);
    check_cursor("restart_cursor", 0, 0);
    read_row(0, 8'h20);
    read_row(1, 8'h20);
    read_cell(16, 59, 8'h20);

    // Continuous 0x09 across the row-16 wrap: 60 accepted, 60 blocked, 80 accepted
    for (int i = 0; i < 16; i++) send(8'h80);
    check_cursor("pre_stream_cursor", 16, 0);
    WrData  = 8'h09;
    WrValid = 1'b1;
    hs = 0;
    repeat (200) begin
      if (WrReady) hs++;
      @(negedge PixelClk);
    end
    WrValid = 1'b0;
    check("stream_handshakes", hs, 140);
    check_cursor("stream_cursor", 1, 20);
    check("stream_busy", Busy, 0);

    drain();
    count_en = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r == 16 || r == 0 || (r == 1 && c < 20)) read_cell(r, c, 8'h09);
        else                                         read_cell(r, c, 8'h20);
      end
    end
    drain();
    count_en = 1'b0;
    check("stored_09_vs_handshakes", count9, hs);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
